// File: rtl/irig_frame_accumulator_if.sv
// Bit-classifier to frame-accumulator link: per-bit strobes in, committed timestamp out.
interface irig_frame_accumulator_if #(
  parameter int unsigned SBS_WIDTH = 17
);
  logic                 bit_valid;
  logic [2:0]           ts_select;
  logic [3:0]           bit_idx;
  logic [1:0]           digit_idx;
  logic                 bit_value;
  logic                 frame_start;
  logic                 frame_end;

  logic [5:0]           ts_second;
  logic [5:0]           ts_minute;
  logic [4:0]           ts_hour;
  logic [8:0]           ts_day;
  logic [6:0]           ts_year;
  logic [SBS_WIDTH-1:0] ts_sec_day;
  logic                 ts_valid;
  logic                 ts_err;
  logic [15:0]          frame_cnt;

  modport master (
    output bit_valid, ts_select, bit_idx, digit_idx, bit_value, frame_start, frame_end,
    input  ts_second, ts_minute, ts_hour, ts_day, ts_year, ts_sec_day, ts_valid, ts_err,
           frame_cnt
  );

  modport slave (
    input  bit_valid, ts_select, bit_idx, digit_idx, bit_value, frame_start, frame_end,
    output ts_second, ts_minute, ts_hour, ts_day, ts_year, ts_sec_day, ts_valid, ts_err,
           frame_cnt
  );
endinterface

// File: rtl/irig_frame_accumulator.sv
// Accumulates IRIG BCD/SBS bits into working fields and commits them atomically on frame end,
// with per-digit BCD validity and field range checking.
module irig_frame_accumulator #(
  parameter int unsigned SBS_WIDTH = 17,
  parameter bit          YEAR_EN   = 1'b1,
  parameter bit          CHECK_EN  = 1'b1
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  irig_frame_accumulator_if.slave bus_io
);

  typedef struct packed {
    logic [5:0]           sec;
    logic [5:0]           min;
    logic [4:0]           hour;
    logic [8:0]           day;
    logic [6:0]           year;
    logic [SBS_WIDTH-1:0] sbs;
  } fields_t;

  fields_t    work_q, work_d, add, upd, ts_q, ts_d;
  logic       err_q, err_d;
  logic [3:0] shadow_q, shadow_d;
  logic [2:0] last_sel_q, last_sel_d;
  logic [1:0] last_dig_q, last_dig_d;
  logic       valid_q, valid_d;
  logic       ts_err_q, ts_err_d;
  logic [15:0] cnt_q, cnt_d;

  logic        is_bcd, is_sbs, idx_err, err_keep, err_fresh, err_upd, range_err;
  logic [15:0] pow10, weight;
  logic [5:0]  sbs_pos;
  logic [3:0]  bit_nib, shadow_keep;

  always_comb begin
    is_bcd = bus_io.bit_valid && (bus_io.ts_select >= 3'd1) && (bus_io.ts_select <= 3'd5) &&
             (YEAR_EN || (bus_io.ts_select != 3'd5));
    is_sbs = bus_io.bit_valid && (bus_io.ts_select == 3'd6);

    case (bus_io.digit_idx)
      2'd0:    pow10 = 16'd1;
      2'd1:    pow10 = 16'd10;
      2'd2:    pow10 = 16'd100;
      default: pow10 = 16'd1000;
    endcase
    weight = bus_io.bit_value ? 16'((16'd1 << bus_io.bit_idx) * pow10) : '0;

    add = '0;
    if (is_bcd) begin
      case (bus_io.ts_select)
        3'd1:    add.sec  = weight[5:0];
        3'd2:    add.min  = weight[5:0];
        3'd3:    add.hour = weight[4:0];
        3'd4:    add.day  = weight[8:0];
        default: add.year = weight[6:0];
      endcase
    end

    // Bits landing beyond the configured SBS width are dropped.
    sbs_pos = 6'(bus_io.digit_idx) * 6'd9 + 6'(bus_io.bit_idx);
    for (int unsigned i = 0; i < SBS_WIDTH; i++) begin
      if (sbs_pos == 6'(i)) add.sbs[i] = is_sbs && bus_io.bit_value;
    end

    upd.sec  = work_q.sec + add.sec;
    upd.min  = work_q.min + add.min;
    upd.hour = work_q.hour + add.hour;
    upd.day  = work_q.day + add.day;
    upd.year = work_q.year + add.year;
    upd.sbs  = work_q.sbs | add.sbs;

    // Shadow nibble restarts whenever the (field, decade) pair changes between strobes.
    bit_nib = '0;
    if (bus_io.bit_value && (bus_io.bit_idx < 4'd4)) bit_nib[bus_io.bit_idx[1:0]] = 1'b1;
    shadow_keep = (((bus_io.ts_select == last_sel_q) && (bus_io.digit_idx == last_dig_q)) ?
                   shadow_q : 4'd0) | bit_nib;
    idx_err   = (bus_io.bit_idx > 4'd3) || (bus_io.digit_idx == 2'd3);
    err_keep  = CHECK_EN && is_bcd && (idx_err || (shadow_keep > 4'd9));
    err_fresh = CHECK_EN && is_bcd && idx_err;
    err_upd   = err_q || err_keep;
    range_err = (upd.sec > 6'd59) || (upd.min > 6'd59) || (upd.hour > 5'd23) ||
                (upd.day == 9'd0) || (upd.day > 9'd366);

    work_d     = upd;
    err_d      = err_upd;
    shadow_d   = is_bcd ? shadow_keep : shadow_q;
    last_sel_d = is_bcd ? bus_io.ts_select : last_sel_q;
    last_dig_d = is_bcd ? bus_io.digit_idx : last_dig_q;
    if (bus_io.frame_start) begin
      if (bus_io.frame_end) begin
        // Commit already took the bit; the next frame starts empty.
        work_d   = '0;
        err_d    = 1'b0;
        shadow_d = '0;
      end else begin
        work_d   = add;
        err_d    = err_fresh;
        shadow_d = is_bcd ? bit_nib : 4'd0;
      end
    end

    ts_d     = ts_q;
    ts_err_d = ts_err_q;
    cnt_d    = cnt_q;
    valid_d  = bus_io.frame_end;
    if (bus_io.frame_end) begin
      ts_d     = upd;
      ts_err_d = CHECK_EN && (err_upd || range_err);
      cnt_d    = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      work_q     <= '0;
      err_q      <= 1'b0;
      shadow_q   <= '0;
      last_sel_q <= '0;
      last_dig_q <= '0;
      ts_q       <= '0;
      valid_q    <= 1'b0;
      ts_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      work_q     <= work_d;
      err_q      <= err_d;
      shadow_q   <= shadow_d;
      last_sel_q <= last_sel_d;
      last_dig_q <= last_dig_d;
      ts_q       <= ts_d;
      valid_q    <= valid_d;
      ts_err_q   <= ts_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus_io.ts_second  = ts_q.sec;
  assign bus_io.ts_minute  = ts_q.min;
  assign bus_io.ts_hour    = ts_q.hour;
  assign bus_io.ts_day     = ts_q.day;
  assign bus_io.ts_year    = YEAR_EN ? ts_q.year : 7'd0;
  assign bus_io.ts_sec_day = ts_q.sbs;
  assign bus_io.ts_valid   = valid_q;
  assign bus_io.ts_err     = ts_err_q;
  assign bus_io.frame_cnt  = cnt_q;

endmodule

// File: tb/tb_irig_frame_accumulator.sv
// Directed bench: default-configured DUT plus a narrow-SBS, no-year, no-check DUT on shared stimulus.
`timescale 1ns / 1ps
module tb_irig_frame_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  irig_frame_accumulator_if #(.SBS_WIDTH(17)) m_if ();
  irig_frame_accumulator_if #(.SBS_WIDTH(10)) a_if ();

  assign a_if.bit_valid   = m_if.bit_valid;
  assign a_if.ts_select   = m_if.ts_select;
  assign a_if.bit_idx     = m_if.bit_idx;
  assign a_if.digit_idx   = m_if.digit_idx;
  assign a_if.bit_value   = m_if.bit_value;
  assign a_if.frame_start = m_if.frame_start;
  assign a_if.frame_end   = m_if.frame_end;

  irig_frame_accumulator #(.SBS_WIDTH(17), .YEAR_EN(1'b1), .CHECK_EN(1'b1)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (m_if)
  );

  irig_frame_accumulator #(.SBS_WIDTH(10), .YEAR_EN(1'b0), .CHECK_EN(1'b0)) u_alt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (a_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [2:0] sel, input logic [1:0] dig, input logic [3:0] idx,
                        input logic val);
    m_if.bit_valid = 1'b1;
    m_if.ts_select = sel;
    m_if.digit_idx = dig;
    m_if.bit_idx   = idx;
    m_if.bit_value = val;
    @(posedge clk);
    #1;
    m_if.bit_valid = 1'b0;
  endtask

  task automatic send_bcd(input logic [2:0] sel, input int value);
    int pw;
    pw = 1;
    for (int d = 0; d < 3; d++) begin
      for (int b = 0; b < 4; b++) strobe(sel, 2'(d), 4'(b), (((value / pw) % 10) >> b) & 1);
      pw = pw * 10;
    end
  endtask

  task automatic send_sbs(input int value);
    for (int p = 0; p < 27; p++) strobe(3'd6, 2'(p / 9), 4'(p % 9), (value >> p) & 1);
  endtask

  task automatic start_frame();
    m_if.frame_start = 1'b1;
    @(posedge clk);
    #1;
    m_if.frame_start = 1'b0;
  endtask

  task automatic end_frame(input logic start);
    m_if.frame_end   = 1'b1;
    m_if.frame_start = start;
    @(posedge clk);
    #1;
    m_if.frame_end   = 1'b0;
    m_if.frame_start = 1'b0;
    exp_cnt++;
    check("valid_pulse", m_if.ts_valid, 1);
    check("frame_cnt", m_if.frame_cnt, exp_cnt);
    @(posedge clk);
    #1;
    check("valid_drop", m_if.ts_valid, 0);
  endtask

  initial begin
    m_if.bit_valid   = 1'b0;
    m_if.ts_select   = '0;
    m_if.bit_idx     = '0;
    m_if.digit_idx   = '0;
    m_if.bit_value   = 1'b0;
    m_if.frame_start = 1'b0;
    m_if.frame_end   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sec", m_if.ts_second, 0);
    check("rst_sec_day", m_if.ts_sec_day, 0);
    check("rst_valid", m_if.ts_valid, 0);
    check("rst_cnt", m_if.frame_cnt, 0);
    rst_n = 1'b1;

    // 12:34:56, day 123, year 24, SBS 45296
    start_frame();
    send_bcd(3'd1, 56);
    send_bcd(3'd2, 34);
    send_bcd(3'd3, 12);
    send_bcd(3'd4, 123);
    send_bcd(3'd5, 24);
    send_sbs(45296);
    end_frame(1'b0);
    check("f1_sec", m_if.ts_second, 56);
    check("f1_min", m_if.ts_minute, 34);
    check("f1_hour", m_if.ts_hour, 12);
    check("f1_day", m_if.ts_day, 123);
    check("f1_year", m_if.ts_year, 24);
    check("f1_sec_day", m_if.ts_sec_day, 45296);
    check("f1_err", m_if.ts_err, 0);
    check("alt_sec_day", a_if.ts_sec_day, 240);
    check("alt_year", a_if.ts_year, 0);
    repeat (4) @(posedge clk);
    #1;
    check("hold_sec", m_if.ts_second, 56);

    // Units nibble 1010 on seconds
    start_frame();
    strobe(3'd1, 2'd0, 4'd1, 1'b1);
    strobe(3'd1, 2'd0, 4'd3, 1'b1);
    send_bcd(3'd4, 5);
    end_frame(1'b0);
    check("nib_sec", m_if.ts_second, 10);
    check("nib_err", m_if.ts_err, 1);
    check("alt_nocheck_err", a_if.ts_err, 0);

    start_frame();
    send_bcd(3'd1, 3);
    send_bcd(3'd2, 2);
    send_bcd(3'd3, 1);
    send_bcd(3'd4, 200);
    end_frame(1'b0);
    check("clean_err", m_if.ts_err, 0);
    check("clean_day", m_if.ts_day, 200);

    // Start and end in the same cycle commit the pre-clear minute
    start_frame();
    send_bcd(3'd2, 7);
    send_bcd(3'd4, 1);
    end_frame(1'b1);
    check("se_min", m_if.ts_minute, 7);
    check("se_err", m_if.ts_err, 0);
    end_frame(1'b0);
    check("empty_min", m_if.ts_minute, 0);
    check("empty_err", m_if.ts_err, 1);

    // Bit, start and end together: bit joins the commit, then everything clears
    send_bcd(3'd1, 4);
    send_bcd(3'd4, 9);
    m_if.bit_valid   = 1'b1;
    m_if.ts_select   = 3'd1;
    m_if.digit_idx   = 2'd0;
    m_if.bit_idx     = 4'd0;
    m_if.bit_value   = 1'b1;
    m_if.frame_start = 1'b1;
    m_if.frame_end   = 1'b1;
    @(posedge clk);
    #1;
    m_if.bit_valid   = 1'b0;
    m_if.frame_start = 1'b0;
    m_if.frame_end   = 1'b0;
    exp_cnt++;
    check("all3_sec", m_if.ts_second, 5);
    check("all3_day", m_if.ts_day, 9);
    check("all3_err", m_if.ts_err, 0);
    check("all3_cnt", m_if.frame_cnt, exp_cnt);
    end_frame(1'b0);
    check("after_all3_sec", m_if.ts_second, 0);

    // SBS bit at position 12 falls outside the narrow DUT
    start_frame();
    send_sbs(5);
    strobe(3'd6, 2'd1, 4'd3, 1'b1);
    send_bcd(3'd4, 1);
    send_bcd(3'd5, 24);
    end_frame(1'b0);
    check("sbs_wide", m_if.ts_sec_day, 4101);
    check("sbs_narrow", a_if.ts_sec_day, 5);
    check("year_en", m_if.ts_year, 24);
    check("year_dis", a_if.ts_year, 0);

    // Reset mid-frame, with frame_end asserted during reset
    start_frame();
    send_bcd(3'd1, 30);
    rst_n          = 1'b0;
    m_if.frame_end = 1'b1;
    @(posedge clk);
    #1;
    rst_n          = 1'b1;
    m_if.frame_end = 1'b0;
    exp_cnt        = '0;
    check("rst_mid_valid", m_if.ts_valid, 0);
    check("rst_mid_cnt", m_if.frame_cnt, 0);
    check("rst_mid_sec", m_if.ts_second, 0);
    end_frame(1'b0);
    check("post_rst_sec", m_if.ts_second, 0);
    check("post_rst_sec_day", m_if.ts_sec_day, 0);
    check("post_rst_err", m_if.ts_err, 1);

    start_frame();
    send_bcd(3'd3, 24);
    send_bcd(3'd4, 1);
    end_frame(1'b0);
    check("hour24_val", m_if.ts_hour, 24);
    check("hour24_err", m_if.ts_err, 1);

    // Continuous frame_end until the counter wraps
    m_if.frame_end = 1'b1;
    repeat (65533 - int'(exp_cnt) + 2) @(posedge clk);
    #1;
    check("cnt_max", m_if.frame_cnt, 16'hFFFF);
    @(posedge clk);
    #1;
    m_if.frame_end = 1'b0;
    check("cnt_wrap", m_if.frame_cnt, 0);
    check("cnt_wrap_valid", m_if.ts_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irig_frame_accumulator.md
# irig_frame_accumulator

Parametrised accumulator for decoded IRIG time-code fields: sits between the IRIG bit-classifier FSM and the timestamp consumers. Accumulates per-bit BCD weights and straight-binary-seconds (SBS) bits into working registers during a frame, validates every BCD digit and field range, then commits all fields atomically to double-buffered outputs on frame end. A one-cycle `ts_valid` strobe and an error flag accompany each commit, so downstream logic never sees a half-built timestamp.

## Interface
- `SBS_WIDTH`, 17: width of SBS seconds-of-day field, 1..18.
- `YEAR_EN`, 1: 1 = accumulate year field; 0 = year selects ignored, `ts_year` held 0.
- `CHECK_EN`, 1: 1 = BCD digit and range checks drive `ts_err`; 0 = `ts_err` tied 0.

- `clk` in 1: system clock.
- `rst` in 1: reset; one clock domain, reset is synchronous and active-low.
- `bit_valid` in 1: one-cycle strobe; the bit fields below are sampled only when high.
- `ts_select` in 3: 1 sec, 2 min, 3 hour, 4 day, 5 year, 6 SBS; 0 and 7 are ignored.
- `bit_idx` in 4: BCD weight bit, 0..3; SBS sub-position, 0..8.
- `digit_idx` in 2: BCD decade, 0..2; SBS group.
- `bit_value` in 1: decoded bit.
- `frame_start` in 1: clears working registers and the error state.
- `frame_end` in 1: commits working registers to the outputs.
- `ts_second` out 6, `ts_minute` out 6, `ts_hour` out 5, `ts_day` out 9, `ts_year` out 7: committed fields.
- `ts_sec_day` out SBS_WIDTH: committed SBS field.
- `ts_valid` out 1: one-cycle commit strobe.
- `ts_err` out 1: error flag for the committed frame.
- `frame_cnt` out 16: commit counter, wraps at 0xFFFF to 0.

## Operation
- BCD accumulate (select 1-5, `bit_valid`=1, `bit_value`=1): add `(1<<bit_idx) * 10^digit_idx` to the working field. Addition is modulo field width.
- `bit_value`=0 adds nothing, but still takes part in digit tracking.
- SBS (select 6): position p = 9*`digit_idx` + `bit_idx`. If p < SBS_WIDTH, set working bit p (OR-in). If p >= SBS_WIDTH, drop the bit silently.
- Digit tracking: a 4-bit shadow nibble is cleared when (`ts_select`,`digit_idx`) differs from the previous valid strobe, or on `frame_start`. The current bit is ORed into the shadow.
- Sticky `err_acc` is set when any of the following occurs:
  - the shadow exceeds 9;
  - `bit_idx` > 3 on a BCD select;
  - `digit_idx` = 3 on a BCD select.
- Range check at commit: `err_acc` is also ORed with sec > 59, min > 59, hour > 23, day = 0, day > 366.
- With CHECK_EN=0, all checks are skipped and `ts_err` = 0.
- Commit on `frame_end`:
  - all six output fields load from the working registers;
  - `ts_err` loads the final error;
  - `frame_cnt` increments;
  - working registers are NOT cleared.
- Simultaneous events:
  - `frame_end` with `frame_start`: commit pre-clear values, then working registers clear.
  - `frame_start` with `bit_valid`: working field = 0 + this bit's contribution; error = this bit's error only.
  - `frame_end` with `bit_valid`: the bit is included in the commit.
  - all three together: commit includes the bit, then working registers clear.
- `frame_end` with no prior `frame_start` commits whatever has accumulated; this is legal.

## Timing
- Reset (`rst`=0 at an edge): all working registers, outputs, shadow, `err_acc`, `ts_valid`, `ts_err` and `frame_cnt` go to 0.
- Reset overrides all strobes in the same cycle. Reset mid-frame discards the partial frame and produces no commit.
- Accumulate latency: the working register updates at the edge that samples `bit_valid`. Back-to-back strobes every cycle are supported.
- Commit latency: outputs and `ts_valid` (=1) change at the edge sampling `frame_end`. `ts_valid` returns to 0 next edge unless `frame_end` is high again.
- Outputs hold their value between commits. No backpressure; consumers must capture on `ts_valid`.

## Test plan
- Frame 12:34:56, day 123, year 24, SBS 45296 -> after `frame_end`: sec=56, min=34, hour=12, day=123, year=24, sec_day=45296, `ts_valid` 1-cycle pulse, `ts_err`=0, `frame_cnt`=1.
- Seconds units digit bits 1 and 3 both set (nibble 10) -> `ts_err`=1 at commit. Next frame with clean data and `frame_start` -> `ts_err`=0.
- `frame_start`+`frame_end` same cycle after minute=7 accumulated -> `ts_minute`=7 committed. A following commit with no bits -> `ts_minute`=0, `ts_err`=1 (day=0).
- SBS_WIDTH=10, SBS bit at p=12 -> ignored, `ts_sec_day` unchanged. YEAR_EN=0 with year bits -> `ts_year`=0.
- `rst`=0 mid-frame, then `frame_end` -> outputs all 0, `frame_cnt`=1, no stale data.
- 65536 commits -> `frame_cnt` wraps to 0. Hour 24 encoded -> `ts_err`=1.
